// File: rtl/fluxo_dados_param.sv
// Modulo-N up/down counter with saturating load, compare against chaves,
// wrap pulse/counter and per-nibble active-low 7-segment display.
module fluxo_dados_param #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16,
    parameter int VWIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     zera,
    input  logic                     carrega,
    input  logic                     conta,
    input  logic                     decrementa,
    input  logic                     para_igual,
    input  logic [WIDTH-1:0]         chaves,
    output logic [WIDTH-1:0]         db_contagem,
    output logic                     menor,
    output logic                     maior,
    output logic                     igual,
    output logic                     fim,
    output logic                     fim_pulso,
    output logic [VWIDTH-1:0]        voltas,
    output logic [7*(WIDTH/4)-1:0]   display
);
    localparam int                DIGITS  = WIDTH / 4;
    localparam logic [WIDTH-1:0]  TERM    = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]    MOD_EXT = (WIDTH + 1)'(MODULO);
    localparam logic [VWIDTH-1:0] VMAX    = '1;

    logic             step;
    logic [WIDTH-1:0] load_val;

    assign igual = (db_contagem == chaves);
    assign menor = (db_contagem <  chaves);
    assign maior = (db_contagem >  chaves);

    // fim doubles as "the next step is a wrap" for the current direction
    assign fim      = decrementa ? (db_contagem == '0) : (db_contagem == TERM);
    assign step     = conta && !(para_igual && igual);
    assign load_val = ({1'b0, chaves} < MOD_EXT) ? chaves : TERM;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_contagem <= '0;
            voltas      <= '0;
            fim_pulso   <= 1'b0;
        end else begin
            fim_pulso <= 1'b0;
            if (zera) begin
                db_contagem <= '0;
                voltas      <= '0;
            end else if (carrega) begin
                db_contagem <= load_val;
                voltas      <= '0;
            end else if (step) begin
                if (decrementa)
                    db_contagem <= fim ? TERM : db_contagem - 1'b1;
                else
                    db_contagem <= fim ? '0 : db_contagem + 1'b1;
                if (fim) begin
                    fim_pulso <= 1'b1;
                    if (voltas != VMAX)
                        voltas <= voltas + 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        fluxo_hex7seg u_seg (
            .nibble (db_contagem[4*k +: 4]),
            .seg    (display[7*k +: 7])
        );
    end
endmodule

// One hex digit, active-low segments, bit 0 = a ... bit 6 = g.
module fluxo_hex7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'b1111111;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

// File: tb/tb_fluxo_dados_param.sv
// Bench for fluxo_dados_param: vector table, corner sequences and random
// stimulus against an arithmetic reference model (MODULO=10 and MODULO=200).
module tb_fluxo_dados_param;
    localparam int M = 10;

    logic clock = 1'b0;
    logic reset;
    logic zera, carrega, conta, decrementa, para_igual;
    logic [3:0] chaves, db_contagem, voltas;
    logic menor, maior, igual, fim, fim_pulso;
    logic [6:0] display;

    logic z8, c8, ct8, d8, p8;
    logic [7:0] ch8, cnt8;
    logic [3:0] voltas8;
    logic menor8, maior8, igual8, fim8, pulso8;
    logic [13:0] display8;

    always #5 clock = ~clock;

    fluxo_dados_param #(.WIDTH(4), .MODULO(M), .VWIDTH(4)) dut (
        .clock(clock), .reset(reset), .zera(zera), .carrega(carrega), .conta(conta),
        .decrementa(decrementa), .para_igual(para_igual), .chaves(chaves),
        .db_contagem(db_contagem), .menor(menor), .maior(maior), .igual(igual),
        .fim(fim), .fim_pulso(fim_pulso), .voltas(voltas), .display(display));

    fluxo_dados_param #(.WIDTH(8), .MODULO(200), .VWIDTH(4)) dut8 (
        .clock(clock), .reset(reset), .zera(z8), .carrega(c8), .conta(ct8),
        .decrementa(d8), .para_igual(p8), .chaves(ch8),
        .db_contagem(cnt8), .menor(menor8), .maior(maior8), .igual(igual8),
        .fim(fim8), .fim_pulso(pulso8), .voltas(voltas8), .display(display8));

    logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_chk = 0, n_fail = 0;
    int m_cnt, m_vol;
    logic m_pul;

    typedef struct {
        logic z, c, ct, d, p;
        logic [3:0] ch;
        int e_cnt;
        logic e_fim, e_pul;
        int e_vol;
    } vec_t;
    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_vol = 0; m_pul = 1'b0;
    endtask

    // Next state from the rules in plain integer arithmetic
    task automatic model_step();
        int ch;
        logic wrap;
        ch = int'(chaves);
        m_pul = 1'b0;
        if (zera) begin
            m_cnt = 0; m_vol = 0;
        end else if (carrega) begin
            m_cnt = (ch < M) ? ch : M - 1; m_vol = 0;
        end else if (conta && !(para_igual && m_cnt == ch)) begin
            wrap  = decrementa ? (m_cnt == 0) : (m_cnt == M - 1);
            m_cnt = decrementa ? (m_cnt + M - 1) % M : (m_cnt + 1) % M;
            if (wrap) begin
                m_pul = 1'b1;
                if (m_vol < 15) m_vol++;
            end
        end
    endtask

    task automatic check_model();
        int ch;
        ch = int'(chaves);
        chk("cnt", db_contagem, m_cnt);
        chk("fim", fim, decrementa ? (m_cnt == 0) : (m_cnt == M - 1));
        chk("fim_pulso", fim_pulso, m_pul);
        chk("voltas", voltas, m_vol);
        chk("cmp", {menor, igual, maior}, {m_cnt < ch, m_cnt == ch, m_cnt > ch});
        chk("display", display, segtab[m_cnt]);
        chk("xfree", $isunknown({db_contagem, fim, fim_pulso, voltas, menor, igual, maior, display}), 0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic z, c, ct, d, p, input logic [3:0] ch);
        zera = z; carrega = c; conta = ct; decrementa = d; para_igual = p; chaves = ch;
    endtask

    initial begin
        tbl[0]  = '{0,1,0,0,0,4'd7,  7,0,0,0};
        tbl[1]  = '{0,1,0,0,0,4'd12, 9,1,0,0};
        tbl[2]  = '{1,1,0,0,0,4'd12, 0,0,0,0};
        tbl[3]  = '{0,1,0,0,0,4'd8,  8,0,0,0};
        tbl[4]  = '{0,0,1,0,0,4'd8,  9,1,0,0};
        tbl[5]  = '{0,0,1,0,0,4'd8,  0,0,1,1};
        tbl[6]  = '{0,0,1,0,0,4'd8,  1,0,0,1};
        tbl[7]  = '{0,0,1,1,0,4'd8,  0,1,0,1};
        tbl[8]  = '{0,0,1,1,0,4'd8,  9,0,1,2};
        tbl[9]  = '{0,0,1,0,0,4'd8,  0,0,1,3};
        tbl[10] = '{0,1,0,0,0,4'd3,  3,0,0,0};
        tbl[11] = '{0,0,1,0,1,4'd6,  4,0,0,0};
        tbl[12] = '{0,0,1,0,1,4'd6,  5,0,0,0};
        tbl[13] = '{0,0,1,0,1,4'd6,  6,0,0,0};
        tbl[14] = '{0,0,1,0,1,4'd6,  6,0,0,0};
        tbl[15] = '{0,0,1,0,1,4'd8,  7,0,0,0};
        tbl[16] = '{0,0,1,0,1,4'd8,  8,0,0,0};
        tbl[17] = '{0,0,1,0,1,4'd8,  8,0,0,0};

        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 4'd0);
        z8 = 0; c8 = 0; ct8 = 0; d8 = 0; p8 = 0; ch8 = 8'd0;
        model_reset();
        #12;
        check_model();
        reset = 1'b0;
        tick();
        check_model();

        foreach (tbl[i]) begin
            set_in(tbl[i].z, tbl[i].c, tbl[i].ct, tbl[i].d, tbl[i].p, tbl[i].ch);
            tick();
            chk($sformatf("vec%0d_cnt", i), db_contagem, tbl[i].e_cnt);
            chk($sformatf("vec%0d_fim", i), fim, tbl[i].e_fim);
            chk($sformatf("vec%0d_pulse", i), fim_pulso, tbl[i].e_pul);
            chk($sformatf("vec%0d_voltas", i), voltas, tbl[i].e_vol);
            check_model();
        end
        chk("hold_igual", igual, 1);

        // 200 down-steps from 0 give 20 wraps; voltas saturates
        set_in(0, 1, 0, 1, 0, 4'd0);
        tick();
        set_in(0, 0, 1, 1, 0, 4'd0);
        for (int i = 0; i < 200; i++) begin
            tick();
            check_model();
        end
        chk("voltas_sat", voltas, 15);

        // asynchronous reset mid-count, no clock edge
        set_in(0, 1, 0, 0, 0, 4'd5);
        tick();
        chk("pre_reset_cnt", db_contagem, 5);
        set_in(0, 0, 0, 0, 0, 4'd5);
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_cnt", db_contagem, 0);
        chk("async_voltas", voltas, 0);
        chk("async_pulse", fim_pulso, 0);
        chk("async_fim_up", fim, 0);
        chk("async_display", display, 7'b1000000);
        chk("async_menor", menor, 1);
        decrementa = 1'b1;
        #1;
        chk("async_fim_dn", fim, 1);
        reset = 1'b0;
        decrementa = 1'b0;

        // reset discards a pending wrap pulse
        set_in(0, 1, 0, 0, 0, 4'd9);
        tick();
        set_in(0, 0, 1, 0, 0, 4'd9);
        tick();
        chk("pulse_before_reset", fim_pulso, 1);
        reset = 1'b1;
        #1;
        model_reset();
        chk("pulse_killed", fim_pulso, 0);
        reset = 1'b0;
        tick();
        chk("first_step_after_release", db_contagem, 1);
        check_model();

        // random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
                   1'($urandom_range(1)), $urandom_range(3) == 0, 4'($urandom_range(15)));
            tick();
            check_model();
        end

        // 8-bit instance: two digits, saturating load, wrap at 199
        set_in(0, 0, 0, 0, 0, 4'd0);
        c8 = 1; ch8 = 8'hC7;
        tick();
        chk("w8_load", cnt8, 8'hC7);
        chk("w8_display", display8, {7'b1000110, 7'b1111000});
        chk("w8_fim", fim8, 1);
        c8 = 0; ct8 = 1;
        tick();
        chk("w8_wrap_cnt", cnt8, 0);
        chk("w8_wrap_pulse", pulso8, 1);
        chk("w8_voltas", voltas8, 1);
        chk("w8_display0", display8, {7'b1000000, 7'b1000000});
        ct8 = 0; c8 = 1; ch8 = 8'hFF;
        tick();
        chk("w8_sat_load", cnt8, 199);
        chk("w8_pulse_clear", pulso8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
